lfsr_rng_server: RTL and testbench

//  Shares one 17-bit XNOR LFSR random source between NREQ requesters.
//  - Round-robin arbitration; at most one value handed out per cycle.
//  - Seed load and post-reset/post-seed warm-up sequencing.
//  - Serves jitter/backoff/replacement-policy logic that needs non-colliding random values.

---
 rtl/lfsr_pkg.sv | 17 +
 rtl/rr_arb.sv | 34 +++
 rtl/lfsr_rng_server.sv | 103 ++++++++++
 tb/tb_lfsr_rng_server.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, tap position and step function for the LFSR random server
package lfsr_pkg;

    // Feedback tap for the 18-bit state register c[17:0] (17-bit output).
    localparam int LFSR_TAP = 14;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } lfsr_srv_state_t;

    // One XNOR LFSR step. All-ones is the lock-up state and never leaves itself.
    function automatic logic [17:0] lfsr17_next(input logic [17:0] c);
        return {c[16:0], ~(c[17] ^ c[LFSR_TAP])};
    endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin pick starting after the last winner
// Ports:
//   req    in  NREQ          eligible requesters
//   last   in  $clog2(NREQ)  previous winner; search begins at last+1
//   any    out 1             at least one requester eligible
//   winner out $clog2(NREQ)  chosen index (equals last when any=0)
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] winner
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // Walk from the farthest offset down to last+1 so the closest eligible
    // index after last is the final assignment that sticks.
    always_comb begin
        any    = 1'b0;
        winner = last;
        idx    = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/lfsr_rng_server.sv
// rtl/lfsr_rng_server.sv - one XNOR LFSR shared round-robin among NREQ requesters
// Ports:
//   clk, rst  clock; synchronous active-high reset
//   req       in  NREQ          per-requester request level
//   ack       out NREQ          registered one-hot grant pulse
//   dat       out WID           random value, valid while ack != 0
//   gnt_id    out $clog2(NREQ)  granted index, valid with ack
//   ready     out 1             serving requests (RUN state)
//   seed_ld   in  1             load seed this edge
//   seed      in  WID+1         new LFSR state
module lfsr_rng_server
    import lfsr_pkg::*;
#(
    parameter int             NREQ    = 4,
    parameter int             WID     = 17,
    parameter logic [WID:0]   RST_VAL = '0,
    parameter int             WARMUP  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         ack,
    output logic [WID-1:0]          dat,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    ready,
    input  logic                    seed_ld,
    input  logic [WID:0]            seed
);
    localparam int IW  = $clog2(NREQ);
    localparam int WCW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP);
    localparam lfsr_srv_state_t ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARM;

    lfsr_srv_state_t state, state_nxt;
    logic [WCW-1:0]  wcnt, wcnt_nxt;
    logic [WID:0]    c, c_step;
    logic [IW-1:0]   last, winner;
    logic            any, grant;

    assign c_step = {c[WID-1:0], ~(c[WID] ^ c[LFSR_TAP])};
    assign ready  = (state == ST_RUN);

    // A requester acked this cycle is masked so a held request is not served twice in a row.
    rr_arb #(.NREQ(NREQ)) u_arb (
        .req    (req & ~ack),
        .last   (last),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            wcnt  <= WARM_INIT;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        grant     = 1'b0;
        if (seed_ld) begin
            state_nxt = ST_INIT;
            wcnt_nxt  = WARM_INIT;
        end else begin
            case (state)
                ST_WARM: begin
                    wcnt_nxt = wcnt - WCW'(1);
                    if (wcnt == WCW'(1)) state_nxt = ST_RUN;
                end
                ST_RUN:  grant = any;
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c      <= RST_VAL;
            ack    <= '0;
            dat    <= '0;
            gnt_id <= '0;
            last   <= IW'(NREQ - 1);
        end else begin
            if (seed_ld) begin
                // All-ones would freeze the XNOR LFSR forever.
                c <= (seed == '1) ? RST_VAL : seed;
            end else begin
                c <= c_step;
            end
            ack <= grant ? (NREQ'(1) << winner) : '0;
            if (grant) begin
                gnt_id <= winner;
                dat    <= c[WID:1];
                last   <= winner;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng_server.sv
// tb/tb_lfsr_rng_server.sv - self-checking bench for lfsr_rng_server (WARMUP=4 and WARMUP=0 instances)
module tb_lfsr_rng_server;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  seed_ld;
    logic [3:0]  req     [2];
    logic [17:0] seed    [2];
    logic [3:0]  ack     [2];
    logic [16:0] dat     [2];
    logic [1:0]  gid     [2];
    logic [1:0]  ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lfsr_rng_server #(.NREQ(4), .WID(17), .RST_VAL(18'h0), .WARMUP(4)) u_w4 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .ack(ack[0]), .dat(dat[0]),
        .gnt_id(gid[0]), .ready(ready[0]), .seed_ld(seed_ld[0]), .seed(seed[0])
    );

    lfsr_rng_server #(.NREQ(4), .WID(17), .RST_VAL(18'h0), .WARMUP(0)) u_w0 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .ack(ack[1]), .dat(dat[1]),
        .gnt_id(gid[1]), .ready(ready[1]), .seed_ld(seed_ld[1]), .seed(seed[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Behavioural model: each edge either resets, reseeds, burns a warm-up step,
    // or picks the next eligible requester after the previous winner.
    logic [17:0] m_c    [2];
    logic [3:0]  m_ack  [2];
    logic [16:0] m_dat  [2];
    int          m_gid  [2];
    int          m_last [2];
    int          m_wleft[2];
    bit          m_valid[2] = '{0, 0};

    function automatic logic [17:0] lfsr_model(input logic [17:0] v);
        logic [17:0] fb;
        fb = ~((v >> 17) ^ (v >> 14)) & 18'h1;
        return ((v << 1) & 18'h3FFFF) | fb;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int warm;
            warm = (d == 0) ? 4 : 0;
            if (rst[d]) begin
                m_valid[d] = 1;
                m_c[d]     = 18'h0;
                m_ack[d]   = 4'h0;
                m_dat[d]   = 17'h0;
                m_gid[d]   = 0;
                m_last[d]  = 3;
                m_wleft[d] = warm;
            end else if (m_valid[d]) begin
                if (seed_ld[d]) begin
                    m_c[d]     = (seed[d] == 18'h3FFFF) ? 18'h0 : seed[d];
                    m_ack[d]   = 4'h0;
                    m_wleft[d] = warm;
                end else begin
                    if (m_wleft[d] > 0) begin
                        m_wleft[d] = m_wleft[d] - 1;
                        m_ack[d]   = 4'h0;
                    end else begin
                        logic [3:0] elig;
                        int         w;
                        elig = req[d] & ~m_ack[d];
                        w = -1;
                        for (int k = 1; k <= 4; k++)
                            if (w < 0 && elig[(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
                        if (w >= 0) begin
                            m_ack[d]  = 4'(1 << w);
                            m_dat[d]  = m_c[d][17:1];
                            m_gid[d]  = w;
                            m_last[d] = w;
                        end else begin
                            m_ack[d] = 4'h0;
                        end
                    end
                    m_c[d] = lfsr_model(m_c[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_valid[d]) begin
                chk($sformatf("model.ack%0d", d),   32'(ack[d]),   32'(m_ack[d]));
                chk($sformatf("model.ready%0d", d), 32'(ready[d]), 32'(m_wleft[d] == 0));
                chk($sformatf("model.dat%0d", d),   32'(dat[d]),   32'(m_dat[d]));
                chk($sformatf("model.gnt%0d", d),   32'(gid[d]),   32'(m_gid[d]));
            end
        end
    end

    int n;
    logic [3:0]  s2_ack [5] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1};
    logic [16:0] s2_dat [5] = '{17'h0, 17'h0, 17'h1, 17'h1, 17'h7};
    int s3_a [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int s3_b [6] = '{1, 3, 0, 1, 3, 0};

    initial begin
        rst = 2'b11; seed_ld = 2'b00;
        req[0] = 4'h0; req[1] = 4'h0; seed[0] = 18'h0; seed[1] = 18'h0;
        tick(); tick();
        chk("s1.ready_reset", 32'(ready[0]), 32'h0);
        chk("s6.gnt_reset",   32'(gid[1]),   32'h0);
        rst = 2'b00; req[0] = 4'b0001; req[1] = 4'b0001;

        // Scenario 1 on the WARMUP=4 instance, scenario 2 on the WARMUP=0 instance.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("s2.ack[%0d]", i), 32'(ack[1]), 32'(s2_ack[i]));
            if (s2_ack[i] != 0) chk($sformatf("s2.dat[%0d]", i), 32'(dat[1]), 32'(s2_dat[i]));
            chk($sformatf("s1.ready[%0d]", i), 32'(ready[0]), (i < 3) ? 32'h0 : 32'h1);
            chk($sformatf("s1.ack[%0d]", i),   32'(ack[0]),   (i < 4) ? 32'h0 : 32'h1);
        end
        chk("s1.dat_first", 32'(dat[0]), 32'h7);

        // Scenario 3: all request, then drop req[2].
        req[1] = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("s3.gnt[%0d]", i), 32'(gid[1]), 32'(s3_a[i]));
            chk($sformatf("s3.ack[%0d]", i), 32'(ack[1]), 32'(1 << s3_a[i]));
        end
        req[1] = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("s3.skip[%0d]", i), 32'(gid[1]), 32'(s3_b[i]));
        end
        req[1] = 4'h0;

        // Scenario 4: seed load beats a simultaneous request.
        req[0] = 4'b0010; seed_ld[0] = 1'b1; seed[0] = 18'h00002;
        tick();
        chk("s4.ack_on_seed", 32'(ack[0]),   32'h0);
        chk("s4.ready_low",   32'(ready[0]), 32'h0);
        seed_ld[0] = 1'b0;
        n = 0;
        while (ack[0] == 4'h0 && n < 12) begin tick(); n++; end
        chk("s4.latency", 32'(n), 32'd5);
        chk("s4.dat",     32'(dat[0]), 32'd23);
        chk("s4.gnt",     32'(gid[0]), 32'd1);

        // Scenario 6: reset on the edge after a grant.
        rst[0] = 1'b1;
        tick();
        chk("s6.ack",   32'(ack[0]),   32'h0);
        chk("s6.ready", 32'(ready[0]), 32'h0);
        chk("s6.gnt",   32'(gid[0]),   32'h0);
        rst[0] = 1'b0;
        n = 0;
        while (ack[0] == 4'h0 && n < 12) begin tick(); n++; end
        chk("s6.rewarm", 32'(n), 32'd5);
        chk("s6.dat",    32'(dat[0]), 32'h7);

        // Scenario 5: lock-up seed replaced by RST_VAL.
        req[1] = 4'b0001; seed_ld[1] = 1'b1; seed[1] = 18'h3FFFF;
        tick();
        chk("s5.ack_on_seed", 32'(ack[1]), 32'h0);
        seed_ld[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("s5.ack[%0d]", i), 32'(ack[1]), 32'(s2_ack[i]));
            if (s2_ack[i] != 0) chk($sformatf("s5.dat[%0d]", i), 32'(dat[1]), 32'(s2_dat[i]));
        end

        // Mixed traffic against the model only.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                req[d]     = 4'($urandom);
                seed_ld[d] = ($urandom_range(0, 24) == 0);
                seed[d]    = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom);
                rst[d]     = ($urandom_range(0, 90) == 0);
            end
            tick();
        end
        rst = 2'b00; seed_ld = 2'b00; req[0] = 4'h0; req[1] = 4'h0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
